// File: rtl/ram_accum_sequencer.sv
// Reads `count` consecutive 512-bit RAM words and sums them lane by lane.
// The per-lane sum is written back to dst_addr and mirrored on sum_out.
module ram_accum_sequencer #(
  parameter int unsigned LANES  = 16,
  parameter int unsigned LANE_W = 32
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic [5:0]                src_base,
  input  logic [6:0]                count,
  input  logic [5:0]                dst_addr,
  output logic                      busy,
  output logic                      done,
  output logic [LANES*LANE_W-1:0]   sum_out,
  output logic [5:0]                ram_addr,
  output logic                      ram_we,
  output logic [LANES*LANE_W-1:0]   ram_wdata,
  input  logic [LANES*LANE_W-1:0]   ram_rdata
);

  typedef enum logic [2:0] {
    StIdle,
    StRead,
    StLast,
    StWrite,
    StDone
  } state_e;

  state_e                    state_q, state_d;
  logic [5:0]                base_q, base_d;
  logic [6:0]                cnt_q, cnt_d;
  logic [5:0]                dst_q, dst_d;
  logic [5:0]                idx_q, idx_d;
  logic [LANES*LANE_W-1:0]   acc_q, acc_d;
  logic [LANES*LANE_W-1:0]   sum_q, sum_d;
  logic [LANES*LANE_W-1:0]   acc_sum;
  logic                      last_read;

  // Independent lane adders; each lane wraps on its own width.
  always_comb begin
    acc_sum = '0;
    for (int k = 0; k < LANES; k++) begin
      acc_sum[k*LANE_W +: LANE_W] = acc_q[k*LANE_W +: LANE_W] + ram_rdata[k*LANE_W +: LANE_W];
    end
  end

  // Counts beyond 64 saturate at a full 64-word sweep.
  assign last_read = ({1'b0, idx_q} == (cnt_q - 7'd1)) || (idx_q == 6'd63);

  always_comb begin
    state_d = state_q;
    base_d  = base_q;
    cnt_d   = cnt_q;
    dst_d   = dst_q;
    idx_d   = idx_q;
    acc_d   = acc_q;
    sum_d   = sum_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          if (count != 7'd0) begin
            base_d  = src_base;
            cnt_d   = count;
            dst_d   = dst_addr;
            idx_d   = 6'd0;
            acc_d   = '0;
            state_d = StRead;
          end else begin
            state_d = StDone;
          end
        end
      end
      StRead: begin
        // Read data lags the address by one cycle, so cycle 0 has nothing to add.
        if (idx_q != 6'd0) begin
          acc_d = acc_sum;
        end
        if (last_read) begin
          state_d = StLast;
        end else begin
          idx_d = idx_q + 6'd1;
        end
      end
      StLast: begin
        acc_d   = acc_sum;
        state_d = StWrite;
      end
      StWrite: begin
        sum_d   = acc_q;
        state_d = StDone;
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // Outputs depend only on registered state, never on inputs.
  always_comb begin
    busy      = (state_q != StIdle);
    done      = (state_q == StDone);
    ram_addr  = 6'd0;
    ram_we    = 1'b0;
    ram_wdata = '0;
    unique case (state_q)
      StRead: begin
        ram_addr = base_q + idx_q;
      end
      StLast: begin
        ram_addr = dst_q;
      end
      StWrite: begin
        ram_addr  = dst_q;
        ram_we    = 1'b1;
        ram_wdata = acc_q;
      end
      default: begin
        ram_addr = 6'd0;
      end
    endcase
  end

  assign sum_out = sum_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      base_q  <= 6'd0;
      cnt_q   <= 7'd0;
      dst_q   <= 6'd0;
      idx_q   <= 6'd0;
      acc_q   <= '0;
      sum_q   <= '0;
    end else begin
      state_q <= state_d;
      base_q  <= base_d;
      cnt_q   <= cnt_d;
      dst_q   <= dst_d;
      idx_q   <= idx_d;
      acc_q   <= acc_d;
      sum_q   <= sum_d;
    end
  end

endmodule

// File: tb/tb_ram_accum_sequencer.sv
// Directed bench for ram_accum_sequencer: table of accumulate commands against a
// behavioural registered-read RAM, plus count=0, busy-start, and mid-command reset.
module tb_ram_accum_sequencer;

  localparam int W = 512;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [5:0]    src_base;
  logic [6:0]    count;
  logic [5:0]    dst_addr;
  logic          busy;
  logic          done;
  logic [W-1:0]  sum_out;
  logic [5:0]    ram_addr;
  logic          ram_we;
  logic [W-1:0]  ram_wdata;
  logic [W-1:0]  ram_rdata;

  always #5 clk = ~clk;

  ram_accum_sequencer #(.LANES(16), .LANE_W(32)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .src_base  (src_base),
    .count     (count),
    .dst_addr  (dst_addr),
    .busy      (busy),
    .done      (done),
    .sum_out   (sum_out),
    .ram_addr  (ram_addr),
    .ram_we    (ram_we),
    .ram_wdata (ram_wdata),
    .ram_rdata (ram_rdata)
  );

  // RAM model: registered-address read; bench preload port has priority.
  logic [W-1:0] mem [64];
  logic         pre_we = 1'b0;
  logic [5:0]   pre_addr = 6'd0;
  logic [W-1:0] pre_data = '0;

  always @(posedge clk) begin
    if (pre_we) mem[pre_addr] <= pre_data;
    else if (ram_we) mem[ram_addr] <= ram_wdata;
    ram_rdata <= mem[ram_addr];
  end

  // Bus monitor
  logic       mon_clr = 1'b0;
  int         busy_cyc;
  int         wr_cnt;
  logic [5:0] wr_addr;
  logic [5:0] addr_log [$];

  always @(negedge clk) begin
    if (mon_clr) begin
      busy_cyc = 0;
      wr_cnt   = 0;
      wr_addr  = 6'd0;
      addr_log.delete();
    end else begin
      if (busy) busy_cyc++;
      if (ram_we) begin
        wr_cnt++;
        wr_addr = ram_addr;
      end else if (busy && !done) begin
        addr_log.push_back(ram_addr);
      end
    end
  end

  int           errors = 0;
  int           checks = 0;
  logic [W-1:0] last_sum = '0;

  task automatic chk_int(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d want %0d", nm, act, exp);
    end
  endtask

  task automatic chk_vec(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic preload(input logic [5:0] src, input int cnt, input logic [31:0] v0,
                         input logic [31:0] step, input logic [31:0] lstep);
    for (int j = 0; j < cnt; j++) begin
      logic [W-1:0] w;
      for (int k = 0; k < 16; k++) w[k*32 +: 32] = 32'(v0 + 32'(j) * step + 32'(k) * lstep);
      @(negedge clk);
      pre_we   = 1'b1;
      pre_addr = 6'(int'(src) + j);
      pre_data = w;
    end
    @(negedge clk);
    pre_we = 1'b0;
  endtask

  task automatic clear_mon();
    mon_clr = 1'b1;
    @(negedge clk);
    #1 mon_clr = 1'b0;
  endtask

  task automatic run(input string nm, input logic [5:0] src, input logic [6:0] cnt,
                     input logic [5:0] dst, input int exp_cyc, input logic [W-1:0] exp_word,
                     input bit poke);
    int done_at;
    int aerr;
    clear_mon();
    start    = 1'b1;
    src_base = src;
    count    = cnt;
    dst_addr = dst;
    @(posedge clk);
    #1;
    start    = 1'b0;
    src_base = ~src;
    count    = 7'd5;
    dst_addr = ~dst;
    done_at  = 0;
    for (int n = 1; n <= 200 && done_at == 0; n++) begin
      @(negedge clk);
      if (poke && n == 2) begin
        start    = 1'b1;
        src_base = src + 6'd20;
        count    = 7'd1;
        dst_addr = dst + 6'd1;
      end
      if (poke && n == 3) start = 1'b0;
      if (done) done_at = n;
    end
    @(negedge clk);
    #1;
    chk_int({nm, " done_cycle"}, done_at, exp_cyc);
    chk_int({nm, " busy_cycles"}, busy_cyc, exp_cyc);
    chk_int({nm, " writes"}, wr_cnt, (cnt == 7'd0) ? 0 : 1);
    if (cnt != 7'd0) begin
      aerr = 0;
      if (addr_log.size() != int'(cnt) + 1) aerr++;
      else begin
        for (int j = 0; j <= int'(cnt); j++) begin
          logic [5:0] ea;
          ea = (j < int'(cnt)) ? 6'(int'(src) + j) : dst;
          if (addr_log[j] != ea) aerr++;
        end
      end
      chk_int({nm, " addr_seq_errs"}, aerr, 0);
      chk_int({nm, " wr_addr"}, int'(wr_addr), int'(dst));
      chk_vec({nm, " ram_dst"}, mem[dst], exp_word);
      chk_vec({nm, " sum_out"}, sum_out, exp_word);
      last_sum = exp_word;
    end else begin
      chk_int({nm, " reads"}, addr_log.size(), 0);
      chk_vec({nm, " sum_out_held"}, sum_out, last_sum);
    end
  endtask

  typedef struct {
    logic [5:0]  src;
    logic [6:0]  cnt;
    logic [5:0]  dst;
    logic [31:0] v0;
    logic [31:0] step;
    logic [31:0] lstep;
    logic [31:0] exp_lane;
    int          cyc;
  } vec_t;

  function automatic logic [W-1:0] exp_of(input vec_t v);
    logic [W-1:0] w;
    for (int k = 0; k < 16; k++) w[k*32 +: 32] = 32'(v.exp_lane + 32'(v.cnt) * 32'(k) * v.lstep);
    return w;
  endfunction

  vec_t vecs [6];

  initial begin
    vecs[0] = '{6'd5,  7'd3,  6'd10, 32'd1,          32'd1,    32'd0, 32'd6,          6};
    vecs[1] = '{6'd62, 7'd4,  6'd20, 32'd1,          32'd0,    32'd0, 32'd4,          7};
    vecs[2] = '{6'd30, 7'd2,  6'd40, 32'hFFFF_FFFF,  32'd0,    32'd0, 32'hFFFF_FFFE,  5};
    vecs[3] = '{6'd8,  7'd2,  6'd9,  32'h10,         32'h10,   32'd1, 32'h30,         5};
    vecs[4] = '{6'd0,  7'd64, 6'd0,  32'd1,          32'd0,    32'd0, 32'h40,         67};
    vecs[5] = '{6'd50, 7'd1,  6'd50, 32'd7,          32'd0,    32'd3, 32'd7,          4};

    // Reset with start held high: reset must win.
    rst = 1'b1; start = 1'b1; src_base = 6'd1; count = 7'd3; dst_addr = 6'd2;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk_int("rst busy", int'(busy), 0);
    chk_int("rst done", int'(done), 0);
    chk_int("rst ram_we", int'(ram_we), 0);
    chk_int("rst ram_addr", int'(ram_addr), 0);
    chk_vec("rst ram_wdata", ram_wdata, '0);
    chk_vec("rst sum_out", sum_out, '0);
    rst = 1'b0; start = 1'b0;

    for (int i = 0; i < 6; i++) begin
      preload(vecs[i].src, int'(vecs[i].cnt), vecs[i].v0, vecs[i].step, vecs[i].lstep);
      run($sformatf("vec%0d", i), vecs[i].src, vecs[i].cnt, vecs[i].dst, vecs[i].cyc,
          exp_of(vecs[i]), 1'b0);
    end

    // count=0: immediate done, no RAM traffic, sum_out held.
    run("cnt0", 6'd3, 7'd0, 6'd5, 1, '0, 1'b0);

    // Start pulsed while busy must not disturb the running command.
    begin
      logic [W-1:0] e;
      for (int k = 0; k < 16; k++) e[k*32 +: 32] = 32'd6;
      preload(6'd12, 3, 32'd2, 32'd0, 32'd0);
      run("busy_start", 6'd12, 7'd3, 6'd33, 6, e, 1'b1);
    end

    // Reset during READ of a count=10 command aborts it.
    begin
      logic [W-1:0] marker;
      for (int k = 0; k < 16; k++) marker[k*32 +: 32] = 32'hA5A5_A5A5;
      preload(6'd0, 10, 32'd1, 32'd0, 32'd0);
      preload(6'd60, 1, 32'hA5A5_A5A5, 32'd0, 32'd0);
      clear_mon();
      start = 1'b1; src_base = 6'd0; count = 7'd10; dst_addr = 6'd60;
      @(posedge clk);
      #1 start = 1'b0;
      repeat (4) @(negedge clk);
      chk_int("abort in_read busy", int'(busy), 1);
      rst = 1'b1;
      @(posedge clk);
      #1;
      chk_int("abort busy", int'(busy), 0);
      chk_int("abort done", int'(done), 0);
      chk_int("abort ram_we", int'(ram_we), 0);
      chk_vec("abort sum_out", sum_out, '0);
      @(negedge clk);
      rst = 1'b0;
      repeat (15) @(negedge clk);
      #1;
      chk_int("abort writes", wr_cnt, 0);
      chk_vec("abort ram_dst", mem[60], marker);
      last_sum = '0;
    end

    preload(vecs[0].src, int'(vecs[0].cnt), vecs[0].v0, vecs[0].step, vecs[0].lstep);
    run("post_abort", vecs[0].src, vecs[0].cnt, vecs[0].dst, vecs[0].cyc, exp_of(vecs[0]), 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ram_accum_sequencer.md
RAM_ACCUM_SEQUENCER -- requirements
Module: ram_accum_sequencer

Interface
REQ-001 Parameter LANES, 16, number of independent adder lanes per RAM word.
REQ-002 Parameter LANE_W, 32, bit width of each lane; LANES*LANE_W SHALL equal 512.
REQ-003 clk  in  1  single clock; all state updates on posedge clk.
REQ-004 rst  in  1  reset, synchronous, active-high.
REQ-005 start  in  1  command strobe; sampled only in IDLE.
REQ-006 src_base  in  6  first RAM address to read.
REQ-007 count  in  7  number of words to accumulate, 0..64.
REQ-008 dst_addr  in  6  RAM address receiving the result.
REQ-009 busy  out  1  high whenever state is not IDLE.
REQ-010 done  out  1  one-cycle pulse at command completion.
REQ-011 sum_out  out  512  registered copy of the last written result.
REQ-012 ram_addr  out  6  address to the RAM.
REQ-013 ram_we  out  1  write enable to the RAM.
REQ-014 ram_wdata  out  512  write data to the RAM.
REQ-015 ram_rdata  in  512  RAM read data, valid the cycle after its address is presented (registered-address read).

Function
REQ-016 States SHALL be IDLE, READ, LAST, WRITE, DONE; all outputs are driven from registers or state only, with no combinational path from input to output.
REQ-017 In IDLE, start=1 with count>=1 SHALL latch src_base, count and dst_addr, clear the accumulator and counter i to 0, and enter READ.
REQ-018 In IDLE, start=1 with count=0 SHALL go directly to DONE, with no RAM access and sum_out unchanged.
REQ-019 Start while busy SHALL be ignored; latched operands do not change until the next IDLE acceptance.
REQ-020 READ SHALL last exactly count cycles; in cycle i it drives ram_addr=(src_base+i) mod 64 and ram_we=0.
REQ-021 In READ cycles with i>=1 and in LAST, every lane SHALL update acc[k] <= acc[k] + ram_rdata[k], modulo 2^LANE_W, with no carry between lanes.
REQ-022 After READ cycle i=count-1, the state SHALL become LAST for one cycle, which consumes the final word with ram_addr=dst_addr and ram_we=0.
REQ-023 WRITE SHALL last one cycle with ram_addr=dst_addr, ram_we=1, ram_wdata=acc, and sum_out<=acc.
REQ-024 DONE SHALL last one cycle with done=1, then return to IDLE; start SHALL be accepted in the cycle after DONE, and not during DONE.
REQ-025 Latency: with start sampled at edge E0, done is high in cycle count+3 after E0, and busy is high for count+3 cycles.
REQ-026 Source ranges SHALL wrap modulo 64; when dst_addr lies inside the source range, the result uses the pre-write values because all reads precede the write.
REQ-027 In IDLE and DONE, ram_addr=0, ram_we=0 and ram_wdata=0.

Reset
REQ-028 On rst=1 at a clock edge: state=IDLE, busy=0, done=0, ram_we=0, ram_addr=0, ram_wdata=0, sum_out=0, accumulator and counters cleared.
REQ-029 Reset SHALL take priority over start and all state transitions.
REQ-030 Reset asserted mid-command SHALL abort it with no RAM write and no done pulse; ram_we is 0 from the first cycle after the reset edge.

Verification
REQ-031 RAM[5..7] lanes all =1,2,3; start, src_base=5, count=3, dst_addr=10 -> each lane of RAM[10] =6, done in cycle 6, sum_out matches.
REQ-032 Wrap: src_base=62, count=4, RAM[62,63,0,1] lanes =1 -> reads addresses 62,63,0,1 and result lanes =4.
REQ-033 Lane overflow: two words with every lane 0xFFFFFFFF -> every lane 0xFFFFFFFE, with no carry between lanes.
REQ-034 count=0 -> no ram_we, done one cycle after start, sum_out unchanged; a start asserted during busy has no effect.
REQ-035 Overlap: src_base=0, count=64, dst_addr=0, all lanes =1 -> RAM[0] lanes =64 (value 0x40).
REQ-036 rst asserted during READ of a count=10 command -> no write to dst_addr, busy=0 and done=0 after reset, and a following command completes correctly.
